// File: rtl/sys_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sys_bridge_pkg
// Shared definitions for the processor-side system bridge and its timers.
//   - Timer register word offsets inside a timer window (CTRL, PRESET, COUNT)
//   - CTRL bit positions and MODE encodings
//   - Timer FSM state encoding (2-bit)
//   - Data-memory word address bound (DM occupies byte 0x0000..0x2FFC)
// No ports; imported by sys_bridge and timer_tc.
// -----------------------------------------------------------------------------
package sys_bridge_pkg;

    // Word offsets of the timer registers within a timer window
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // Number of words in one timer window (byte base..base+0xB)
    localparam logic [29:0] TC_WINDOW_WORDS = 30'd3;

    // CTRL bit positions; the upper bits [31:4] always read as zero
    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE_L = 1;
    localparam int CTRL_MODE_H = 2;
    localparam int CTRL_IM     = 3;

    // MODE encodings; 2'b1x behaves like one-shot
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    // Timer FSM states
    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tcState_t;

    // Highest data-memory word address (byte 0x2FFC); DM starts at word 0
    localparam logic [29:0] DM_WORD_HI = 30'h0000_0BFF;

    // Periodic mode is the only encoding that reloads after an interrupt
    function automatic logic isPeriodic(input logic [3:0] ctrl);
        return ctrl[CTRL_MODE_H:CTRL_MODE_L] == MODE_PERIODIC;
    endfunction

endpackage

// File: rtl/sys_bridge_timer_tc.sv
// -----------------------------------------------------------------------------
// timer_tc
// One MMIO timer/counter: CTRL, PRESET and read-only COUNT registers, the
// IDLE/LOAD/CNT/INT state machine and the masked interrupt output.
// Ports:
//   i_clk     in   1   clock, rising edge
//   i_reset   in   1   asynchronous active-high reset
//   i_we      in   1   write strobe, already qualified by the window decode
//   i_offset  in   2   register word offset within the window
//   i_wdata   in   32  write data
//   o_rdata   out  32  combinational read data for i_offset
//   o_irq     out  1   IM & irq flag
// -----------------------------------------------------------------------------
module timer_tc
    import sys_bridge_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irqFlag;
    tcState_t    r_state;

    logic        w_ctrlWe;
    logic        w_presetWe;

    assign w_ctrlWe   = i_we && (i_offset == OFF_CTRL);
    assign w_presetWe = i_we && (i_offset == OFF_PRESET);

    // Register read mux; unimplemented CTRL bits and the unused fourth word read 0
    always_comb begin
        o_rdata = 32'd0;
        case (i_offset)
            OFF_CTRL:   o_rdata = {28'd0, r_ctrl};
            OFF_PRESET: o_rdata = r_preset;
            OFF_COUNT:  o_rdata = r_count;
            default:    o_rdata = 32'd0;
        endcase
    end

    // Register writes, interrupt flag and counter FSM in one block so the
    // INT state can override the EN bit of a same-cycle CTRL write.
    // A flag set in INT wins over the clear from a CTRL write, so an expiry
    // coinciding with a CTRL write is never lost. In periodic mode the flag
    // is only held for the cycle after INT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ctrl    <= 4'd0;
            r_preset  <= 32'd0;
            r_count   <= 32'd0;
            r_irqFlag <= 1'b0;
            r_state   <= TC_IDLE;
        end else begin
            if (w_ctrlWe) begin
                r_ctrl <= i_wdata[3:0];
            end
            if (w_presetWe) begin
                r_preset <= i_wdata;
            end

            if (r_state == TC_INT) begin
                r_irqFlag <= 1'b1;
            end else if (w_ctrlWe || isPeriodic(r_ctrl)) begin
                r_irqFlag <= 1'b0;
            end

            case (r_state)
                TC_IDLE: begin
                    if (r_ctrl[CTRL_EN]) begin
                        r_state <= TC_LOAD;
                    end
                end
                TC_LOAD: begin
                    r_count <= r_preset;
                    r_state <= (r_preset == 32'd0) ? TC_INT : TC_CNT;
                end
                TC_CNT: begin
                    if (r_ctrl[CTRL_EN]) begin
                        if (r_count > 32'd1) begin
                            r_count <= r_count - 32'd1;
                        end else begin
                            r_count <= 32'd0;
                            r_state <= TC_INT;
                        end
                    end
                end
                TC_INT: begin
                    if (isPeriodic(r_ctrl)) begin
                        r_state <= TC_LOAD;
                    end else begin
                        r_ctrl[CTRL_EN] <= 1'b0;
                        r_state         <= TC_IDLE;
                    end
                end
                default: r_state <= TC_IDLE;
            endcase
        end
    end

    assign o_irq = r_ctrl[CTRL_IM] & r_irqFlag;

endmodule

// File: rtl/sys_bridge.sv
// -----------------------------------------------------------------------------
// sys_bridge
// Processor-side system bridge: decodes PrAddr into two timer windows,
// routes writes, muxes read data back onto PrRD and merges the timer
// interrupts and a synchronised external interrupt onto HWInt[7:2].
// Optional feature macro: BRIDGE_ADDR_ERR_EN adds the addr_err output.
// Ports:
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous active-high reset
//   PrAddr    in   30  word address [31:2]
//   PrWD      in   32  write data
//   PrWe      in   1   write strobe
//   ext_int   in   1   asynchronous external interrupt level
//   PrRD      out  32  combinational read data
//   HWInt     out  6   [2]=TC0, [3]=TC1, [4]=ext_int synced, [7:5]=0
//   addr_err  out  1   (BRIDGE_ADDR_ERR_EN only) one-cycle pulse after a
//                      write outside both timers and outside data memory
// -----------------------------------------------------------------------------
module sys_bridge
    import sys_bridge_pkg::*;
#(
    parameter logic [31:0] TC0_BASE        = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE        = 32'h0000_7F10,
    parameter int          EXT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic        PrWe,
    input  logic        ext_int,
    output logic [31:0] PrRD,
    output logic [7:2]  HWInt
`ifdef BRIDGE_ADDR_ERR_EN
    ,
    output logic        addr_err
`endif
);

    localparam logic [29:0] TC0_WBASE = TC0_BASE[31:2];
    localparam logic [29:0] TC1_WBASE = TC1_BASE[31:2];

    logic [29:0] w_tc0Off;
    logic [29:0] w_tc1Off;
    logic        w_hit0;
    logic        w_hit1;
    logic [31:0] w_tc0Rdata;
    logic [31:0] w_tc1Rdata;
    logic        w_tc0Irq;
    logic        w_tc1Irq;
    logic [EXT_SYNC_STAGES-1:0] r_extSync;

    // Window hit: the unsigned distance from the base wraps to a large value
    // below the base, so a single compare covers both window edges.
    assign w_tc0Off = PrAddr - TC0_WBASE;
    assign w_tc1Off = PrAddr - TC1_WBASE;
    assign w_hit0   = w_tc0Off < TC_WINDOW_WORDS;
    assign w_hit1   = w_tc1Off < TC_WINDOW_WORDS;

    timer_tc u_tc0 (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_we     (PrWe & w_hit0),
        .i_offset (w_tc0Off[1:0]),
        .i_wdata  (PrWD),
        .o_rdata  (w_tc0Rdata),
        .o_irq    (w_tc0Irq)
    );

    timer_tc u_tc1 (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_we     (PrWe & w_hit1),
        .i_offset (w_tc1Off[1:0]),
        .i_wdata  (PrWD),
        .o_rdata  (w_tc1Rdata),
        .o_irq    (w_tc1Irq)
    );

    // Read mux; anything outside the timer windows reads 0
    always_comb begin
        PrRD = 32'd0;
        if (w_hit0) begin
            PrRD = w_tc0Rdata;
        end else if (w_hit1) begin
            PrRD = w_tc1Rdata;
        end
    end

    // External interrupt synchroniser; the last stage drives HWInt[4]
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_extSync <= '0;
        end else begin
            r_extSync <= {r_extSync[EXT_SYNC_STAGES-2:0], ext_int};
        end
    end

    assign HWInt = {3'b000, r_extSync[EXT_SYNC_STAGES-1], w_tc1Irq, w_tc0Irq};

`ifdef BRIDGE_ADDR_ERR_EN
    logic r_addrErr;

    // Flag writes that land nowhere: not a timer and beyond data memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addrErr <= 1'b0;
        end else begin
            r_addrErr <= PrWe && !w_hit0 && !w_hit1 && (PrAddr > DM_WORD_HI);
        end
    end

    assign addr_err = r_addrErr;
`endif

endmodule

// File: tb/tb_sys_bridge.sv
// -----------------------------------------------------------------------------
// tb_sys_bridge
// Directed self-checking bench for sys_bridge: timer one-shot and periodic
// operation, zero preset, asynchronous reset mid-count, unmapped accesses,
// external interrupt synchroniser latency and interrupt masking.
// -----------------------------------------------------------------------------
module tb_sys_bridge;

    localparam int STAGES = 2;

    logic        clk;
    logic        reset;
    logic [29:0] PrAddr;
    logic [31:0] PrWD;
    logic        PrWe;
    logic        ext_int;
    logic [31:0] PrRD;
    logic [7:2]  HWInt;
`ifdef BRIDGE_ADDR_ERR_EN
    logic        addr_err;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // Expected TC1 COUNT and IRQ for cycles 1..12 after enabling periodic PRESET=3
    int   perCount [12] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
    logic perIrq   [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    sys_bridge #(
        .TC0_BASE        (32'h0000_7F00),
        .TC1_BASE        (32'h0000_7F10),
        .EXT_SYNC_STAGES (STAGES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .PrAddr  (PrAddr),
        .PrWD    (PrWD),
        .PrWe    (PrWe),
        .ext_int (ext_int),
        .PrRD    (PrRD),
        .HWInt   (HWInt)
`ifdef BRIDGE_ADDR_ERR_EN
        ,
        .addr_err(addr_err)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One bus write; called at a negedge, returns at the negedge after the write edge
    task automatic applyStimulus(input logic [31:0] byteAddr, input logic [31:0] data);
        PrAddr = byteAddr[31:2];
        PrWD   = data;
        PrWe   = 1'b1;
        @(negedge clk);
        PrWe   = 1'b0;
        PrWD   = 32'd0;
    endtask

    // Combinational read of a byte address, checked against a constant
    task automatic readCheck(input string tag, input logic [31:0] byteAddr,
                             input logic [31:0] expected);
        PrAddr = byteAddr[31:2];
        #1;
        checkOutput(tag, PrRD, expected);
    endtask

    task automatic hwCheck(input string tag, input logic [5:0] expected);
        checkOutput(tag, {26'd0, HWInt}, {26'd0, expected});
    endtask

    // Main directed sequence
    initial begin
        reset   = 1'b1;
        PrAddr  = 30'd0;
        PrWD    = 32'd0;
        PrWe    = 1'b0;
        ext_int = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        readCheck("rst_ctrl0", 32'h7F00, 32'd0);
        readCheck("rst_preset0", 32'h7F04, 32'd0);
        readCheck("rst_count1", 32'h7F18, 32'd0);
        hwCheck("rst_hwint", 6'b000000);

        // One-shot TC0, PRESET=5
        applyStimulus(32'h7F04, 32'd5);
        applyStimulus(32'h7F00, 32'h9);
        @(negedge clk);
        readCheck("os_load_count", 32'h7F08, 32'd0);
        for (int v = 5; v >= 0; v--) begin
            @(negedge clk);
            readCheck($sformatf("os_count_%0d", v), 32'h7F08, v);
        end
        hwCheck("os_irq_before", 6'b000000);
        @(negedge clk);
        hwCheck("os_irq_set", 6'b000001);
        readCheck("os_ctrl_en_clr", 32'h7F00, 32'h8);
        repeat (3) @(negedge clk);
        hwCheck("os_irq_sticky", 6'b000001);
        readCheck("os_count_hold", 32'h7F08, 32'd0);

        // CTRL write clears the sticky flag
        applyStimulus(32'h7F00, 32'h8);
        hwCheck("os_irq_cleared", 6'b000000);
        readCheck("os_count_after_clr", 32'h7F08, 32'd0);

        // Periodic TC1, PRESET=3
        applyStimulus(32'h7F14, 32'd3);
        applyStimulus(32'h7F10, 32'hB);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            readCheck($sformatf("per_count_k%0d", k + 1), 32'h7F18, perCount[k]);
            hwCheck($sformatf("per_irq_k%0d", k + 1), perIrq[k] ? 6'b000010 : 6'b000000);
        end
        applyStimulus(32'h7F10, 32'h0);

        // Zero preset: LOAD goes straight to INT, count never underflows
        applyStimulus(32'h7F04, 32'd0);
        applyStimulus(32'h7F00, 32'h9);
        @(negedge clk);
        readCheck("zp_load_count", 32'h7F08, 32'd0);
        @(negedge clk);
        readCheck("zp_int_count", 32'h7F08, 32'd0);
        hwCheck("zp_irq_before", 6'b000000);
        @(negedge clk);
        hwCheck("zp_irq_set", 6'b000001);
        readCheck("zp_no_underflow", 32'h7F08, 32'd0);
        readCheck("zp_ctrl", 32'h7F00, 32'h8);

        // Asynchronous reset in the middle of a count
        applyStimulus(32'h7F04, 32'd10);
        applyStimulus(32'h7F00, 32'h9);
        repeat (5) @(negedge clk);
        readCheck("mid_count_7", 32'h7F08, 32'd7);
        reset = 1'b1;
        #1;
        readCheck("ar_count0", 32'h7F08, 32'd0);
        readCheck("ar_ctrl0", 32'h7F00, 32'd0);
        readCheck("ar_preset0", 32'h7F04, 32'd0);
        readCheck("ar_preset1", 32'h7F14, 32'd0);
        hwCheck("ar_hwint", 6'b000000);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        readCheck("ar_idle_count", 32'h7F08, 32'd0);

        // Decode: TC1 write does not touch TC0
        applyStimulus(32'h7F14, 32'h0000_1234);
        readCheck("dec_preset1", 32'h7F14, 32'h0000_1234);
        readCheck("dec_preset0", 32'h7F04, 32'd0);

        // Unmapped word inside the TC0 block reads 0, writes are dropped
        readCheck("unm_read", 32'h7F0C, 32'd0);
        applyStimulus(32'h7F0C, 32'hFFFF_FFFF);
`ifdef BRIDGE_ADDR_ERR_EN
        checkOutput("aerr_pulse", {31'd0, addr_err}, 32'd1);
`endif
        readCheck("unm_ctrl0", 32'h7F00, 32'd0);
        readCheck("unm_preset0", 32'h7F04, 32'd0);
        readCheck("unm_count0", 32'h7F08, 32'd0);
        readCheck("unm_ctrl1", 32'h7F10, 32'd0);
`ifdef BRIDGE_ADDR_ERR_EN
        @(negedge clk);
        checkOutput("aerr_one_cycle", {31'd0, addr_err}, 32'd0);
        applyStimulus(32'h0000_0100, 32'h1);
        checkOutput("aerr_dm_ok", {31'd0, addr_err}, 32'd0);
`endif

        // External interrupt latency through the synchroniser
        ext_int = 1'b1;
        for (int e = 1; e < STAGES; e++) begin
            @(negedge clk);
            hwCheck($sformatf("ext_wait_%0d", e), 6'b000000);
        end
        @(negedge clk);
        hwCheck("ext_rise", 6'b000100);

        // Masked timer interrupt never reaches HWInt
        applyStimulus(32'h7F04, 32'd2);
        applyStimulus(32'h7F00, 32'h1);
        repeat (8) @(negedge clk);
        readCheck("im0_expired", 32'h7F00, 32'd0);
        readCheck("im0_count", 32'h7F08, 32'd0);
        hwCheck("im0_masked", 6'b000100);

        ext_int = 1'b0;
        repeat (STAGES) @(negedge clk);
        hwCheck("ext_fall", 6'b000000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
